// File: rtl/int_rr_sched_if.sv
// Interrupt service handshake between scheduler and CPU.
// Scheduler drives the request; CPU answers with ack and eoi.
interface int_rr_sched_if #(
  parameter int ID_W = 3
);
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;
  logic            eoi;

  modport master (
    output irq,
    output irq_id,
    input  irq_ack,
    input  eoi
  );

  modport slave (
    input  irq,
    input  irq_id,
    output irq_ack,
    output eoi
  );
endinterface

// File: rtl/int_rr_sched.sv
// Round-robin interrupt scheduler: edge capture, pending,
// masked selection and REQ/SERVICE handshake sequencing.
module int_rr_sched #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] src_mask,
  output logic [NUM_SRC-1:0] pend_status,
  output logic               busy,
  int_rr_sched_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] pending, pending_n;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] edg;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic               irq_r, irq_n;
  logic [ID_W-1:0]    id_r, id_n;
  logic [ID_W-1:0]    last_id, last_n;
  logic               found;
  logic [ID_W-1:0]    sel;

  assign edg  = src_in & ~src_d & src_en;
  assign elig = pending & ~src_mask;

  // First eligible source after last_id, wrapping at NUM_SRC.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(last_id) + k) % NUM_SRC;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // Next-state and handshake decisions.
  always_comb begin
    state_n = state;
    irq_n   = irq_r;
    id_n    = id_r;
    last_n  = last_id;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          id_n    = sel;
          irq_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          clr     = NUM_SRC'(1) << id_r;
          irq_n   = 1'b0;
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          last_n  = id_r;
          state_n = IDLE;
        end
      end
      default: begin
        irq_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
    // A new edge on the source being cleared keeps it pending.
    pending_n = (pending & ~clr) | edg;
  end

  // State, pending and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      src_d   <= '0;
      irq_r   <= 1'b0;
      id_r    <= '0;
      last_id <= ID_W'(NUM_SRC - 1);
    end else begin
      state   <= state_n;
      pending <= pending_n;
      src_d   <= src_in;
      irq_r   <= irq_n;
      id_r    <= id_n;
      last_id <= last_n;
    end
  end

  assign bus.irq     = irq_r;
  assign bus.irq_id  = id_r;
  assign pend_status = pending;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_int_rr_sched.sv
// Bench for int_rr_sched: directed vectors, literal checks
// and a per-cycle comparison against a behavioural model.
module tb_int_rr_sched;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src_in, src_en, src_mask;
  logic [N-1:0] pend_status;
  logic         busy;

  int_rr_sched_if #(.ID_W(W)) bus();

  int_rr_sched #(.NUM_SRC(N), .ID_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_in     (src_in),
    .src_en     (src_en),
    .src_mask   (src_mask),
    .pend_status(pend_status),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 requesting, 2 in service.
  bit mp[N];
  bit mprev[N];
  int mphase;
  int mid;
  int mlast;
  bit mvalid = 0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (mp[i]) begin
        mp[i]    = 0;
        mprev[i] = 0;
      end
      mphase = 0;
      mid    = 0;
      mlast  = N - 1;
      mvalid = 1;
    end else if (mvalid) begin
      int clear_id;
      bit e[N];
      clear_id = -1;
      for (int i = 0; i < N; i++)
        e[i] = src_in[i] && !mprev[i] && src_en[i];
      if (mphase == 0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (mlast + k) % N;
          if (mphase == 0 && mp[j] && !src_mask[j]) begin
            mid    = j;
            mphase = 1;
          end
        end
      end else if (mphase == 1) begin
        if (bus.irq_ack) begin
          clear_id = mid;
          mphase   = 2;
        end
      end else begin
        if (bus.eoi) begin
          mlast  = mid;
          mphase = 0;
        end
      end
      if (clear_id >= 0) mp[clear_id] = 0;
      for (int i = 0; i < N; i++) begin
        if (e[i]) mp[i] = 1;
        mprev[i] = src_in[i];
      end
    end
  end

  function automatic logic [N-1:0] mpend();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mp[i];
    return v;
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_irq", 32'(bus.irq), 32'(mphase == 1));
      chk("m_busy", 32'(busy), 32'(mphase != 0));
      chk("m_pend", 32'(pend_status), 32'(mpend()));
      if (mphase != 0)
        chk("m_id", 32'(bus.irq_id), 32'(mid));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(logic [N-1:0] v);
    src_in = v;
    tick();
    src_in = '0;
  endtask

  task automatic wait_irq(string name);
    int c;
    c = 0;
    while (bus.irq !== 1'b1 && c < 12) begin
      tick();
      c++;
    end
    if (bus.irq !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: irq timeout got %0b expected 1",
               name, bus.irq);
    end
  endtask

  task automatic service(string name, int exp_id);
    wait_irq(name);
    chk(name, 32'(bus.irq_id), 32'(exp_id));
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk({name, "_ack_irq"}, 32'(bus.irq), 32'd0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    src_in      = '0;
    src_en      = 8'hFF;
    src_mask    = '0;
    bus.irq_ack = 1'b0;
    bus.eoi     = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
    chk("rst_pend", 32'(pend_status), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);

    // Basic edge -> pending -> irq -> ack -> eoi.
    src_in = 8'h08;
    tick();
    src_in = '0;
    chk("t1_pend", 32'(pend_status), 32'h08);
    chk("t1_irq0", 32'(bus.irq), 32'd0);
    tick();
    chk("t1_irq", 32'(bus.irq), 32'd1);
    chk("t1_id", 32'(bus.irq_id), 32'd3);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk("t1_ack_pend", 32'(pend_status), 32'h00);
    chk("t1_ack_irq", 32'(bus.irq), 32'd0);
    chk("t1_ack_busy", 32'(busy), 32'd1);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("t1_eoi_busy", 32'(busy), 32'd0);

    // Round-robin order 1,4,6 then wrap 6,1.
    do_reset();
    pulse(8'h52);
    service("t2_a", 1);
    wait_irq("t2_b");
    chk("t2_b", 32'(bus.irq_id), 32'd4);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    pulse(8'h42);
    tick();
    chk("t2_pend", 32'(pend_status), 32'h42);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    service("t2_c", 6);
    service("t2_d", 1);

    // Masked pending source.
    src_mask = 8'h04;
    pulse(8'h04);
    tick(3);
    chk("t3_irq_masked", 32'(bus.irq), 32'd0);
    chk("t3_pend2", 32'(pend_status[2]), 32'd1);
    src_mask = 8'h00;
    wait_irq("t3_unmask");
    chk("t3_id", 32'(bus.irq_id), 32'd2);
    src_mask = 8'h04;
    tick(2);
    chk("t3_hold", 32'(bus.irq), 32'd1);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    src_mask = 8'h00;
    tick();

    // Capture enable gating.
    src_en = 8'hDF;
    pulse(8'h20);
    tick();
    chk("t4_blocked", 32'(pend_status[5]), 32'd0);
    src_in = 8'h20;
    tick();
    src_en = 8'hFF;
    tick(2);
    chk("t4_level", 32'(pend_status[5]), 32'd0);
    src_in = 8'h00;
    tick();
    pulse(8'h20);
    chk("t4_fresh", 32'(pend_status[5]), 32'd1);
    service("t4_svc", 5);

    // Set wins over ack clear.
    pulse(8'h01);
    wait_irq("t5_a");
    chk("t5_id", 32'(bus.irq_id), 32'd0);
    bus.irq_ack = 1'b1;
    src_in = 8'h01;
    tick();
    bus.irq_ack = 1'b0;
    src_in = 8'h00;
    chk("t5_pend0", 32'(pend_status[0]), 32'd1);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    service("t5_again", 0);

    // Reset during SERVICE, then stray handshake in IDLE.
    pulse(8'h22);
    wait_irq("t6_a");
    chk("t6_id", 32'(bus.irq_id), 32'd1);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    pulse(8'h02);
    chk("t6_pend", 32'(pend_status), 32'h22);
    chk("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_irq", 32'(bus.irq), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_pend", 32'(pend_status), 32'h00);
    bus.eoi     = 1'b1;
    bus.irq_ack = 1'b1;
    tick();
    bus.eoi     = 1'b0;
    bus.irq_ack = 1'b0;
    chk("t6_stray_busy", 32'(busy), 32'd0);
    chk("t6_stray_irq", 32'(bus.irq), 32'd0);
    chk("t6_stray_pend", 32'(pend_status), 32'h00);
    pulse(8'h80);
    service("t6_after", 7);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
